// File: rtl/enocoro_liner_inv_if.sv
// Byte-stream handshake bundle for the inverse linear layer:
// an input channel (v0, v1) and an output channel (u0, u1).
interface enocoro_liner_inv_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  // Producer of v-bytes / consumer of u-bytes.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The inverse-L block itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/enocoro_liner_inv.sv
// Byte-serial inverse of the Enocoro-128v2 linear layer L over GF(2^8)/0x11D.
// Takes v0 then v1, returns u0 then u1 where u1 = 0xF4*(v0^v1), u0 = v0^u1.
// MUL_SERIAL=1 multiplies with an 8-step MSB-first Horner loop, 0 in one step.
module enocoro_liner_inv #(
  parameter bit MUL_SERIAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync,
  output logic                 busy,
  enocoro_liner_inv_if.slave   bus
);

  // 0xF4 is the multiplicative inverse of 0x03 in this field.
  localparam logic [7:0] K = 8'hF4;

  typedef enum logic [2:0] {
    S_IN0  = 3'd0,
    S_IN1  = 3'd1,
    S_MUL  = 3'd2,
    S_OUT0 = 3'd3,
    S_OUT1 = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] v0_q, v0_d;
  logic [7:0] x_q, x_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] u0_q, u0_d;
  logic [7:0] u1_q, u1_d;

  logic [7:0] step_acc;
  logic [7:0] mul_res;
  logic       mul_done;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Fully unrolled Horner evaluation of K*a, used by the single-step variant.
  function automatic logic [7:0] mul_k(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      r = xtime(r) ^ (K[i] ? a : 8'h00);
    end
    return r;
  endfunction

  // One Horner step: bit index runs 7..0 as the counter runs 0..7.
  assign step_acc = xtime(acc_q) ^ (K[3'd7 - cnt_q] ? x_q : 8'h00);

  generate
    if (MUL_SERIAL) begin : g_serial
      assign mul_res  = step_acc;
      assign mul_done = (cnt_q == 3'd7);
    end else begin : g_parallel
      assign mul_res  = mul_k(x_q);
      assign mul_done = 1'b1;
    end
  endgenerate

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IN0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; sync overrides every state and refuses any input byte.
  always_comb begin
    state_d = state_q;
    if (sync) begin
      state_d = S_IN0;
    end else begin
      case (state_q)
        S_IN0:   if (bus.in_valid)  state_d = S_IN1;
        S_IN1:   if (bus.in_valid)  state_d = S_MUL;
        S_MUL:   if (mul_done)      state_d = S_OUT0;
        S_OUT0:  if (bus.out_ready) state_d = S_OUT1;
        S_OUT1:  if (bus.out_ready) state_d = S_IN0;
        default: state_d = S_IN0;
      endcase
    end
  end

  // Outputs decoded from state only; out_data is forced to zero when idle.
  always_comb begin
    bus.in_ready  = (state_q == S_IN0) || (state_q == S_IN1);
    bus.out_valid = (state_q == S_OUT0) || (state_q == S_OUT1);
    busy          = (state_q == S_MUL) || bus.out_valid;
    case (state_q)
      S_OUT0:  bus.out_data = u0_q;
      S_OUT1:  bus.out_data = u1_q;
      default: bus.out_data = 8'h00;
    endcase
  end

  // Datapath next values; contents are left untouched on sync since the
  // state machine ignores them until fresh bytes are latched.
  always_comb begin
    v0_d  = v0_q;
    x_d   = x_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    u0_d  = u0_q;
    u1_d  = u1_q;
    if (!sync) begin
      case (state_q)
        S_IN0: begin
          if (bus.in_valid) v0_d = bus.in_data;
        end
        S_IN1: begin
          if (bus.in_valid) begin
            x_d   = v0_q ^ bus.in_data;
            acc_d = 8'h00;
            cnt_d = 3'd0;
          end
        end
        S_MUL: begin
          acc_d = step_acc;
          cnt_d = cnt_q + 3'd1;
          if (mul_done) begin
            u1_d = mul_res;
            u0_d = v0_q ^ mul_res;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_q  <= 8'h00;
      x_q   <= 8'h00;
      acc_q <= 8'h00;
      cnt_q <= 3'd0;
      u0_q  <= 8'h00;
      u1_q  <= 8'h00;
    end else begin
      v0_q  <= v0_d;
      x_q   <= x_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      u0_q  <= u0_d;
      u1_q  <= u1_d;
    end
  end

endmodule

// File: doc/enocoro_liner_inv.md
Name: enocoro_liner_inv

Overview:
- Byte-serial inverse of the Enocoro-128v2 linear diffusion layer L over GF(2^8), polynomial x^8+x^4+x^3+x^2+1 (0x11D).
- Forward L maps (u0,u1) to (v0,v1) = (u0^u1, u0^0x02·u1).
- This block accepts v0 then v1 and emits u0 then u1, using a valid/ready handshake on both sides.
- Used by the decryption-side and state-rollback datapath of the 8-bit architecture, and as a bench oracle for the forward linear unit.

Parameters:
- MUL_SERIAL, default 1: 1 = 8-cycle Horner multiplier by 0xF4 (area-optimised); 0 = single-cycle combinational multiply.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- sync  in  1  synchronous abort; returns the block to idle and discards any partial pair
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a byte this cycle
- in_data  in  8  v0 first, then v1
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the byte
- out_data  out  8  u0 first, then u1; 0x00 when out_valid=0
- busy  out  1  high in S_MUL, S_OUT0, S_OUT1

Behaviour:
- Arithmetic:
  - xtime(a) = {a[6:0],0} ^ (a[7] ? 0x1D : 0x00).
  - x = v0^v1; u1 = 0xF4·x (0xF4 = 0x03^-1); u0 = v0^u1.
- Serial multiply (MUL_SERIAL=1), Horner MSB-first over K=0xF4:
  - acc starts at 0.
  - Each cycle: acc <= xtime(acc) ^ (K[i] ? x : 0), for i=7 down to 0.
  - Iteration counter is 3 bits and wraps after i=0.
- Parallel multiply (MUL_SERIAL=0): a single registered step.
- FSM states: S_IN0, S_IN1, S_MUL, S_OUT0, S_OUT1.
  - S_IN0: in_ready=1. On in_valid, latch v0 and go to S_IN1.
  - S_IN1: in_ready=1. On in_valid, latch x=v0^in_data, clear acc and counter, go to S_MUL.
  - S_MUL: in_ready=0. After 8 (serial) or 1 (parallel) cycles, register u1=acc and u0=v0^acc, go to S_OUT0.
  - S_OUT0: out_valid=1, out_data=u0. On out_ready go to S_OUT1.
  - S_OUT1: out_valid=1, out_data=u1. On out_ready go to S_IN0.
- Latency:
  - Serial: if v1 is accepted at edge E, out_valid rises after edge E+8.
  - Parallel: out_valid rises after edge E+1.
- Throughput: no overlap between input and output phases. Minimum pair period is 12 cycles (serial) or 5 cycles (parallel).
- Handshake rules:
  - A transfer occurs on a rising edge where valid and ready are both 1.
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
  - in_ready depends only on state, never combinationally on in_valid.
  - out_ready has no effect while out_valid=0.
- sync:
  - Highest priority after reset, in every state.
  - Next state S_IN0; out_valid=0 next cycle; latched v0/x/acc are don't-care.
  - If sync and in_valid are both high in S_IN0/S_IN1, the byte is NOT accepted.
- Reset values: state S_IN0 (so in_ready=1); out_valid=0; out_data=0x00; busy=0; all data registers 0x00.
- Reset mid-operation (any state): immediate return to reset values. No output byte is emitted for the interrupted pair.
- Back-to-back: a new v0 can be accepted on the first cycle after the u1 transfer edge.

Test Plan:
- Reset, then v0=0x01, v1=0x02 with out_ready=1 -> out_data 0x00 then 0x01. out_valid first high 8 cycles after the v1 edge (serial).
- v0=0x26, v1=0x7A -> u0=0x12, u1=0x34. Repeat with MUL_SERIAL=0; out_valid must be high 1 cycle after the v1 edge.
- v0=0x00, v1=0x01 (tests 0xF4 constant) -> 0xF4, 0xF4. Then v0=0x00, v1=0x9D (tests the reduction path) -> 0x80, 0x80.
- Hold out_ready=0 for 5 cycles in S_OUT0 -> out_data holds at u0, in_ready=0, busy=1. Release -> u0 then u1 are transferred exactly once each.
- Assert sync in S_IN1 (v0 taken) and again in S_MUL -> returns to S_IN0 with out_valid=0. Next pair 0x26/0x7A still yields 0x12/0x34.
- Assert reset_n low in S_OUT1 -> out_valid=0 and out_data=0x00 asynchronously. After release, in_ready=1 and no stale byte appears. Follow with a random pair set checked against forward L via a reference model.
